// File: rtl/reg_f_pkg.sv
// Shared types and sizes for the register-file context stack and its controller.
package reg_f_pkg;

  localparam int NREGS  = 9;
  localparam int RIDX_W = 4;
  localparam int SP_W   = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH   = 3'd1,
    POP_RD = 3'd2,
    POP_WR = 3'd3,
    FIN    = 3'd4
  } state_t;

endpackage

// File: rtl/reg_f_stack_ctrl.sv
// Context-stack sequencer: saves the register file on push, then restores one
// register per cycle from a shadow copy of the top slot on pop.
//
// state  | meaning
// IDLE   | stack addressed at sp (top of stack); accepting push/pop
// PUSH   | stack written at sp+1 from the register file
// POP_RD | top slot captured into the shadow buffer
// POP_WR | shadow[idx] written back to register idx, idx = 1..9
// FIN    | done pulse, sp already updated
module reg_f_stack_ctrl
  import reg_f_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_req,
  input  logic              pop_req,
  input  logic [WIDTH-1:0]  stack1_in,
  input  logic [WIDTH-1:0]  stack2_in,
  input  logic [WIDTH-1:0]  stack3_in,
  input  logic [WIDTH-1:0]  stack4_in,
  input  logic [WIDTH-1:0]  stack5_in,
  input  logic [WIDTH-1:0]  stack6_in,
  input  logic [WIDTH-1:0]  stack7_in,
  input  logic [WIDTH-1:0]  stack8_in,
  input  logic [WIDTH-1:0]  stack9_in,
  output logic [SP_W-1:0]   stk_addr,
  output logic              stk_wren,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic [SP_W-1:0]   sp,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [SP_W-1:0]   SP_MAX   = SP_W'(DEPTH);
  localparam logic [RIDX_W-1:0] IDX_LAST = RIDX_W'(NREGS);

  state_t            state;
  logic [SP_W-1:0]   sp_q;
  logic [RIDX_W-1:0] idx;
  logic              err_q;
  logic [WIDTH-1:0]  shadow [NREGS];
  logic [WIDTH-1:0]  stk_in [NREGS];

  assign stk_in[0] = stack1_in;
  assign stk_in[1] = stack2_in;
  assign stk_in[2] = stack3_in;
  assign stk_in[3] = stack4_in;
  assign stk_in[4] = stack5_in;
  assign stk_in[5] = stack6_in;
  assign stk_in[6] = stack7_in;
  assign stk_in[7] = stack8_in;
  assign stk_in[8] = stack9_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sp_q  <= '0;
      idx   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          // push wins; a pop in the same cycle is dropped, not deferred
          if (push_req) begin
            if (sp_q < SP_MAX) state <= PUSH;
            else               err_q <= 1'b1;
          end else if (pop_req) begin
            if (sp_q != '0) state <= POP_RD;
            else            err_q <= 1'b1;
          end
        end
        PUSH: begin
          sp_q  <= sp_q + 1'b1;
          state <= FIN;
        end
        POP_RD: begin
          for (int i = 0; i < NREGS; i++) shadow[i] <= stk_in[i];
          idx   <= RIDX_W'(1);
          state <= POP_WR;
        end
        POP_WR: begin
          if (idx == IDX_LAST) begin
            sp_q  <= sp_q - 1'b1;
            idx   <= '0;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stk_addr = (state == PUSH) ? sp_q + 1'b1 : sp_q;
    stk_wren = (state == PUSH);
    rf_we    = (state == POP_WR);
    rf_waddr = rf_we ? idx : '0;
    rf_wdata = rf_we ? shadow[idx - 1'b1] : '0;
    sp       = sp_q;
    busy     = (state != IDLE);
    done     = (state == FIN);
    err      = err_q;
  end

endmodule
